// File: rtl/fp_cvt_pkg.sv
// Shared types and constants for the float <-> int32 converter.
package fp_cvt_pkg;

  typedef enum logic [1:0] {
    OP_F2W  = 2'b00,
    OP_F2WU = 2'b01,
    OP_W2F  = 2'b10,
    OP_WU2F = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_NORM,
    ST_PACK,
    ST_DONE
  } state_e;

  localparam int FP_EXP_BIAS = 127;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

  // Bit positions within {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_cvt_lzc32.sv
// 32-bit leading-zero counter; returns 32 for an all-zero input.
module fp_cvt_lzc32 (
  input  logic [31:0] data,
  output logic [5:0]  cnt
);

  // Scanning upward leaves the highest set bit as the final assignment.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fp_cvt_unit.sv
// Multi-cycle IEEE-754 single <-> int32/uint32 converter, round-toward-zero.
// Exception flags are produced only when FP_CVT_FFLAGS_EN is defined.
module fp_cvt_unit
  import fp_cvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_fflags
);

`ifdef FP_CVT_FFLAGS_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif

  state_e            state, state_nxt;
  op_e               op_p0;
  logic [31:0]       data_p0;
  logic              sign_p1, nan_p1, inf_p1, zero_p1;
  logic [7:0]        exp_p1;
  logic [23:0]       sig_p1;
  logic [31:0]       mag_p1;
  logic signed [9:0] e_p2;
  logic [5:0]        sh_p2, lz_p2, lz;
  logic [31:0]       res_pk, data_q;
  logic [4:0]        flg_pk, flags_q;

  function automatic logic [36:0] cvt_f2i(input logic uns, input logic sign,
                                          input logic nan, input logic inf,
                                          input logic zero, input logic signed [9:0] e,
                                          input logic [5:0] sh, input logic [23:0] sig);
    logic [63:0] x;
    logic [31:0] res;
    logic [4:0]  fl;
    res = '0;
    fl  = '0;
    // sig * 2^(e+9): integer part lands in [63:32], discarded fraction in [31:0]
    x   = {40'b0, sig} << sh;
    if (nan) begin
      res = uns ? UINT_MAX : INT_MAX;
      fl[FLAG_NV] = 1'b1;
    end else if (inf) begin
      res = sign ? (uns ? 32'h0 : INT_MIN) : (uns ? UINT_MAX : INT_MAX);
      fl[FLAG_NV] = 1'b1;
    end else if (e < 0) begin
      fl[FLAG_NX] = !zero;
    end else if (uns && sign) begin
      fl[FLAG_NV] = 1'b1;
    end else if (uns && e > 31) begin
      res = UINT_MAX;
      fl[FLAG_NV] = 1'b1;
    end else if (!uns && e > 30) begin
      res = sign ? INT_MIN : INT_MAX;
      fl[FLAG_NV] = !(sign && e == 31 && sig[22:0] == 23'd0);
    end else begin
      res = sign ? -x[63:32] : x[63:32];
      fl[FLAG_NX] = |x[31:0];
    end
    return {fl, res};
  endfunction

  function automatic logic [36:0] cvt_i2f(input logic sign, input logic [31:0] mag,
                                          input logic [5:0] lz_cnt);
    logic [30:0] norm;
    logic [7:0]  ex;
    logic [31:0] res;
    logic [4:0]  fl;
    res  = '0;
    fl   = '0;
    norm = 31'(mag << lz_cnt);
    ex   = 8'(FP_EXP_BIAS + 31 - int'(lz_cnt));
    if (mag != 32'd0) begin
      res = {sign, ex, norm[30:8]};
      fl[FLAG_NX] = |norm[7:0];
    end
    return {fl, res};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = ST_NORM;
      ST_NORM:   state_nxt = ST_PACK;
      ST_PACK:   state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid && !flush) begin
      op_p0   <= op_e'(in_op);
      data_p0 <= in_data;
    end
  end

  // p1: classify float fields and form integer magnitude
  always_ff @(posedge clk) begin
    if (state == ST_UNPACK) begin
      sign_p1 <= data_p0[31];
      exp_p1  <= data_p0[30:23];
      sig_p1  <= {data_p0[30:23] != 8'd0, data_p0[22:0]};
      nan_p1  <= (data_p0[30:23] == 8'hFF) && (data_p0[22:0] != 23'd0);
      inf_p1  <= (data_p0[30:23] == 8'hFF) && (data_p0[22:0] == 23'd0);
      zero_p1 <= (data_p0[30:0] == 31'd0);
      mag_p1  <= (op_p0 == OP_W2F && data_p0[31]) ? -data_p0 : data_p0;
    end
  end

  fp_cvt_lzc32 u_lzc (
    .data (mag_p1),
    .cnt  (lz)
  );

  // p2: unbiased exponent, shift amount, leading-zero count
  always_ff @(posedge clk) begin
    if (state == ST_NORM) begin
      e_p2  <= $signed({2'b00, exp_p1}) - $signed(10'(FP_EXP_BIAS));
      sh_p2 <= 6'(exp_p1 - 8'(FP_EXP_BIAS - 9));
      lz_p2 <= lz;
    end
  end

  always_comb begin
    if (op_p0 == OP_W2F || op_p0 == OP_WU2F)
      {flg_pk, res_pk} = cvt_i2f(sign_p1 && (op_p0 == OP_W2F), mag_p1, lz_p2);
    else
      {flg_pk, res_pk} = cvt_f2i(op_p0 == OP_F2WU, sign_p1, nan_p1, inf_p1, zero_p1,
                                 e_p2, sh_p2, sig_p1);
  end

  // p3: result registers, held stable through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      flags_q <= '0;
    end else if (state == ST_PACK && !flush) begin
      data_q  <= res_pk;
      flags_q <= FLAGS_EN ? flg_pk : 5'b0;
    end
  end

  assign out_data   = data_q;
  assign out_fflags = flags_q;

endmodule
